// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage between ALU and writeback, one outstanding data access.
// Latency: accept -> mem_req next cycle; mem_ack -> wb/st_done pulse next cycle; fault pulses one cycle after accept.
// Backpressure: req_ready only while idle; mem_* held stable until mem_ack or timeout abort.
module load_store_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  // TIMEOUT=0 disables the abort; keep a 1-bit counter so the width stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [4:0]  rd;
  } lsu_req_t;

  state_t     state, state_n;
  lsu_req_t   cur;
  logic [CNT_W-1:0] to_cnt;

  logic       accept;
  logic       f3_legal;
  logic       misaligned;
  logic       fault;
  logic       timeout_hit;
  logic [3:0] strb_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign req_ready   = rst_n && (state == S_IDLE);
  assign accept      = req_valid && req_ready;
  assign fault       = !f3_legal || misaligned;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  assign mem_req   = (state == S_REQ);
  assign wb_valid  = (state == S_DONE) && !cur.is_store;
  assign st_done   = (state == S_DONE) && cur.is_store;
  assign exc_valid = (state == S_ERR);

  // Decode the incoming request: funct3 legality, natural alignment, store lanes.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    strb_n     = 4'b0000;
    wdata_n    = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_is_store;
      default:                f3_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          strb_n  = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          strb_n  = 4'b0011 << req_addr[1:0];
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: strb_n = 4'b1111;
      endcase
    end
  end

  // Select the addressed lane of the returned word and extend it for writeback.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (cur.addr[1:0])
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      2'b11:   ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = cur.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cur.funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // State register; reset drops mem_req immediately and discards any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state: ack beats timeout when both land in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = fault ? S_ERR : S_REQ;
      S_REQ: begin
        if (mem_ack)          state_n = S_DONE;
        else if (timeout_hit) state_n = S_ERR;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Wait counter: cleared on accept, counts REQ cycles without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        to_cnt <= '0;
    else if (accept)                   to_cnt <= '0;
    else if (state == S_REQ && !mem_ack) to_cnt <= to_cnt + CNT_W'(1);
  end

  // Capture request fields, memory-side outputs, and result/exception registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_code  <= '0;
      exc_addr  <= '0;
    end else begin
      if (accept) begin
        cur.is_store <= req_is_store;
        cur.funct3   <= req_funct3;
        cur.addr     <= req_addr;
        cur.rd       <= req_rd;
        if (fault) begin
          exc_code <= !f3_legal ? 2'd2 : (req_is_store ? 2'd1 : 2'd0);
          exc_addr <= req_addr;
        end else begin
          mem_we    <= req_is_store;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wstrb <= strb_n;
          mem_wdata <= wdata_n;
        end
      end
      if (state == S_REQ) begin
        if (mem_ack) begin
          if (!cur.is_store) begin
            wb_data <= ld_ext;
            wb_rd   <= cur.rd;
          end
        end else if (timeout_hit) begin
          exc_code <= 2'd3;
          exc_addr <= cur.addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against load_store_unit with TIMEOUT=4.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: bench only issues when req_ready is expected high.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, st_done, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .st_done(st_done),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request at the current falling edge; returns one cycle later with inputs scrambled.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    chk("ready_before_issue", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    req_funct3 = 3'b111; req_rd = 5'd31;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] ewd);
    issue(1'b1, f3, a, wd, 5'd0);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_strb"}, mem_wstrb, strb);
    chk({tag, "_wdata"}, mem_wdata, ewd);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_st_done"}, st_done, 1);
    chk({tag, "_no_wb"}, wb_valid, 0);
    @(negedge clk);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp_d);
    issue(1'b0, f3, a, 32'h0, rd);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_strb"}, mem_wstrb, 0);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_data"}, wb_data, exp_d);
    chk({tag, "_wb_rd"}, wb_rd, rd);
    @(negedge clk);
    chk({tag, "_wb_pulse_end"}, wb_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  task automatic run_fault(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [1:0] code);
    issue(st, f3, a, 32'h1234_5678, 5'd3);
    chk({tag, "_no_req"}, mem_req, 0);
    chk({tag, "_exc_valid"}, exc_valid, 1);
    chk({tag, "_exc_code"}, exc_code, code);
    chk({tag, "_exc_addr"}, exc_addr, a);
    @(negedge clk);
    chk({tag, "_exc_pulse_end"}, exc_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
    chk({tag, "_still_no_req"}, mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, wb_cnt, first_acc, second_acc;
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pulses", {wb_valid, st_done, exc_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_exc_addr", exc_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // SW with ack after 2 extra cycles: outputs stable for 3 cycles
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0);
    for (int i = 0; i < 3; i++) begin
      chk("sw_req", mem_req, 1);
      chk("sw_addr", mem_addr, 32'h0000_0100);
      chk("sw_strb", mem_wstrb, 4'b1111);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw_ready_low", req_ready, 0);
      chk("sw_no_done_yet", st_done, 0);
      if (i == 2) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("sw_st_done", st_done, 1);
    chk("sw_req_dropped", mem_req, 0);
    chk("sw_ready_m1", req_ready, 0);
    @(negedge clk);
    chk("sw_st_done_once", st_done, 0);
    chk("sw_ready_m2", req_ready, 1);

    run_store("sb", 3'b000, 32'h0000_0203, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    run_store("sh", 3'b001, 32'h0000_0202, 32'h0000_1234, 4'b1100, 32'h1234_1234);

    run_load("lb",  3'b000, 32'h0000_0042, 5'd10, 32'h1280_FF34, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_0042, 5'd11, 32'h1280_FF34, 32'h0000_0080);
    run_load("lh",  3'b001, 32'h0000_0042, 5'd12, 32'h1280_FF34, 32'h0000_1280);
    run_load("lhs", 3'b001, 32'h0000_0040, 5'd13, 32'h1280_FF34, 32'hFFFF_FF34);
    run_load("lhu", 3'b101, 32'h0000_0040, 5'd14, 32'h1280_FF34, 32'h0000_FF34);
    run_load("lw",  3'b010, 32'h0000_0044, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D);

    run_fault("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 2'd0);
    run_fault("sh_mis", 1'b1, 3'b001, 32'h0000_0001, 2'd1);
    run_fault("ld_ill", 1'b0, 3'b011, 32'h0000_0104, 2'd2);
    run_fault("st_ill", 1'b1, 3'b100, 32'h0000_0107, 2'd2);
    chk("wb_data_held", wb_data, 32'hCAFE_F00D);

    // Timeout: mem_req high exactly 4 cycles, then exception code 3
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd5);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", mem_req, 1);
      @(negedge clk);
    end
    chk("to_req_dropped", mem_req, 0);
    chk("to_exc_valid", exc_valid, 1);
    chk("to_exc_code", exc_code, 2'd3);
    chk("to_exc_addr", exc_addr, 32'h0000_0300);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("to_late_ack_no_wb", wb_valid, 0);
    chk("to_ready_back", req_ready, 1);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("to_late_ack_no_wb2", wb_valid, 0);

    // Ack on the last allowed cycle wins over the timeout
    issue(1'b0, 3'b010, 32'h0000_0308, 32'h0, 5'd6);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("edge_req_high", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("edge_wb_valid", wb_valid, 1);
    chk("edge_no_exc", exc_valid, 0);
    chk("edge_wb_data", wb_data, 32'h0BAD_F00D);
    @(negedge clk);

    // Reset in the middle of a request
    issue(1'b1, 3'b010, 32'h0000_0400, 32'h1111_2222, 5'd0);
    chk("rstmid_req_high", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req_async_drop", mem_req, 0);
    chk("rstmid_ready_low", req_ready, 0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_pulses", {wb_valid, st_done, exc_valid}, 0);
      chk("rstmid_ready", req_ready, 1);
    end

    // Back-to-back loads with same-cycle ack: one accept every 3 cycles
    accepts = 0; wb_cnt = 0; first_acc = -1; second_acc = -1;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0500; req_rd = 5'd7; mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    for (int c = 0; c < 9; c++) begin
      if (req_ready) begin
        if (accepts == 0) first_acc = c;
        else if (accepts == 1) second_acc = c;
        accepts++;
      end
      if (wb_valid) wb_cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    chk("b2b_accepts", accepts, 3);
    chk("b2b_spacing", second_acc - first_acc, 3);
    chk("b2b_wb_count", wb_cnt, 3);
    chk("b2b_wb_data", wb_data, 32'h1122_3344);
    chk("b2b_wb_rd", wb_rd, 5'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
